rhs_spi_slave: RTL
==================

Name: rhs_spi_slave

Overview:
- SPI responder for the RHS command link. It models the headstage chip end of the bus so the existing SPI master can be exercised in simulation and in loopback bring-up.
- Receives one 32-bit MSB-first command per CS-low frame on MOSI and returns a 32-bit response on MISO.
- Runs on the fabric clock `clk` and oversamples SCLK, CS and MOSI. SCLK is at most clk/8.
- The received word is presented with a one-cycle valid strobe; malformed frames are flagged.

Parameters:
- DATA_WIDTH, 32, bits per frame; shift register and counter width follow from it.
- SYNC_STAGES, 2, flops in each input synchronizer for SCLK, CS and MOSI (minimum 2).

Ports:
- clk  input  1  fabric clock, rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- SCLK  input  1  SPI clock from master; idles low (mode 0).
- CS  input  1  chip select from master, active-low.
- MOSI  input  1  command data from master.
- MISO  output  1  response data to master.
- resp_data  input  DATA_WIDTH  response word; captured at frame start.
- rx_data  output  DATA_WIDTH  last correctly received command word.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_err  output  1  one-cycle pulse on a frame with bit count != DATA_WIDTH.
- busy  output  1  high while a frame is in progress (state SHIFT).

Behaviour:
- Reset (rstn low, asynchronous) forces:
  - MISO=0, rx_data=0, rx_valid=0, frame_err=0, busy=0;
  - shift registers and bit counter to 0; synchronizers cleared to 0; state RESYNC.
- Inputs pass through SYNC_STAGES flops.
  - Edge detection compares the last sync stage with one additional history flop.
  - Edge events: cs_fall, cs_rise, sclk_rise, sclk_fall.
  - All actions occur on the clk edge where the event is detected; outputs are registered.
- State RESYNC: wait until synced CS=1, then go to IDLE. This guarantees no partial frame is captured after a reset mid-frame.
- State IDLE:
  - MISO=0, busy=0. SCLK and MOSI activity is ignored.
  - On cs_fall:
    - rx shift register is cleared and bit_cnt=0;
    - resp_data is loaded into the tx shift register;
    - MISO = resp_data[DATA_WIDTH-1];
    - busy=1 and state goes to SHIFT.
- State SHIFT:
  - sclk_rise: rx_shift = {rx_shift[DATA_WIDTH-2:0], synced MOSI}. bit_cnt increments and saturates at DATA_WIDTH+1.
  - sclk_fall: tx shifts left with 0 fill; MISO = next bit. After the DATA_WIDTH-th falling edge, MISO=0.
  - cs_rise:
    - if bit_cnt == DATA_WIDTH: rx_data <= rx_shift and rx_valid=1 for one cycle;
    - otherwise frame_err=1 for one cycle and rx_data is unchanged;
    - MISO=0, busy=0, state goes to IDLE.
  - Any SCLK edge detected in the same cycle as cs_rise is ignored.
- Timing:
  - A CS pin rising edge produces rx_valid/frame_err exactly SYNC_STAGES+1 clk cycles later.
  - MISO changes SYNC_STAGES+1 cycles after an SCLK pin falling edge. This is under 4 clk cycles at SYNC_STAGES=2, so it is valid at the next SCLK rising edge.
- resp_data is sampled only at cs_fall; changes during a frame do not affect MISO.
- Back-to-back frames with CS high for at least SYNC_STAGES+1 cycles are each handled fully.

Test Plan:
- Full frame: master sends 0x80FF00AA with resp_data=0x12345678. Required: rx_data=0x80FF00AA, rx_valid high for exactly 1 cycle, master captures 0x12345678, busy low after the frame.
- Back-to-back: frame 1 sends 0xFFFFFFFF with resp=0xA5A5A5A5; resp changes to 0x0F0F0F0F mid-frame; frame 2 sends 0x00000000. Required:
  - rx_valid twice, with rx_data 0xFFFFFFFF then 0x00000000;
  - MISO returns 0xA5A5A5A5 in frame 1 and 0x0F0F0F0F in frame 2.
- Short frame: CS low, 16 SCLK pulses, CS high. Required: frame_err 1-cycle pulse, no rx_valid, rx_data unchanged from the prior value.
- Long frame: 33 SCLK pulses. Required: frame_err pulse, no rx_valid.
- Reset mid-frame: rstn pulsed low after bit 10 and released with CS still low. Required:
  - MISO=0 immediately;
  - no rx_valid or frame_err at the following CS rise;
  - the next full frame with 0x00C0FFEE is received correctly.
- Idle noise: SCLK and MOSI toggling with CS high. Required: MISO=0, busy=0, no rx_valid or frame_err, rx_data unchanged.

Source files
------------

// File: rtl/rhs_spi_slave.sv
// SPI mode-0 responder for the RHS command link. The fabric clock oversamples
// SCLK, CS and MOSI. Each CS-low frame shifts in one command word and shifts
// out the response word that was latched when CS fell.
module rhs_spi_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    // The counter must be able to hold DATA_WIDTH+1, where it saturates.
    localparam int CNT_W = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_hist_q, sclk_hist_d;
    logic                    cs_hist_q, cs_hist_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    miso_q, miso_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    busy_q, busy_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // Synchronizer chains shift toward the MSB; the history flops remember the last stage.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
        cs_hist_d   = cs_sync_q[SYNC_STAGES-1];
    end

    // Edge events come from the last sync stage against its history flop.
    always_comb begin
        sclk_s    = sclk_sync_q[SYNC_STAGES-1];
        cs_s      = cs_sync_q[SYNC_STAGES-1];
        mosi_s    = mosi_sync_q[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_hist_q;
        sclk_fall = ~sclk_s & sclk_hist_q;
        cs_rise   = cs_s & ~cs_hist_q;
        cs_fall   = ~cs_s & cs_hist_q;
    end

    // Frame FSM: next state, shift registers and registered outputs.
    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        miso_d      = miso_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            RESYNC: begin
                miso_d = 1'b0;
                busy_d = 1'b0;
                if (cs_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                miso_d = 1'b0;
                busy_d = 1'b0;
                if (cs_fall) begin
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    tx_shift_d = resp_data;
                    miso_d     = resp_data[DATA_WIDTH-1];
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    miso_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sclk_fall) begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                        miso_d     = tx_shift_q[DATA_WIDTH-2];
                    end
                end
            end
            default: begin
                state_d = RESYNC;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RESYNC;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_hist_q   <= cs_hist_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            miso_q      <= miso_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign MISO      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
